vote_threshold_filter: RTL and testbench



---
 rtl/vote_filter_pkg.sv | 16 +
 rtl/vote_popcount.sv | 19 +
 rtl/vote_threshold_filter.sv | 135 +++++++++++++
 tb/tb_vote_threshold_filter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vote_filter_pkg.sv
// rtl/vote_filter_pkg.sv - shared state encoding and width helper for the vote threshold filter
package vote_filter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_LO      = 2'd0;
    localparam state_t ST_PEND_HI = 2'd1;
    localparam state_t ST_HI      = 2'd2;
    localparam state_t ST_PEND_LO = 2'd3;

    // Bits needed to hold any value 0..n
    function automatic int count_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/vote_popcount.sv
// rtl/vote_popcount.sv - combinational population count of the vote bus
module vote_popcount
    import vote_filter_pkg::*;
#(
    parameter int N_VOTE = 3,
    parameter int THR_W  = count_width(N_VOTE)
) (
    input  logic [N_VOTE-1:0] vote,
    output logic [THR_W-1:0]  count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N_VOTE; i++) begin
            count = count + THR_W'(vote[i]);
        end
    end

endmodule

// File: rtl/vote_threshold_filter.sv
// rtl/vote_threshold_filter.sv - registered K-of-N vote with override, persistence filter and rise counter
module vote_threshold_filter
    import vote_filter_pkg::*;
#(
    parameter int N_VOTE = 3,
    parameter int HOLD   = 4,
    parameter int CNT_W  = 8,
    localparam int THR_W = count_width(N_VOTE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              ovr,
    input  logic [N_VOTE-1:0] vote,
    input  logic [THR_W-1:0]  thr,
    input  logic              cnt_clr,
    output logic              raw,
    output logic              y,
    output logic              rise,
    output logic [CNT_W-1:0]  evt_cnt
);

    localparam int RUN_W = count_width(HOLD);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(HOLD - 1);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [THR_W-1:0] count;
    logic             raw_d;
    logic             raw_ovr;
    state_t           state;
    state_t           state_nxt;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_nxt;
    logic             y_nxt;
    logic             going_up;

    vote_popcount #(
        .N_VOTE (N_VOTE),
        .THR_W  (THR_W)
    ) u_popcount (
        .vote  (vote),
        .count (count)
    );

    // thr=0 always passes; thr above N_VOTE can never be met by votes alone
    assign raw_d = ovr | (count >= thr);

    always_comb begin
        state_nxt = state;
        run_nxt   = run_cnt;
        y_nxt     = y;
        case (state)
            ST_LO: begin
                if (raw_ovr || (raw && HOLD == 1)) begin
                    state_nxt = ST_HI;
                    run_nxt   = '0;
                    y_nxt     = 1'b1;
                end else if (raw) begin
                    state_nxt = ST_PEND_HI;
                    run_nxt   = RUN_ONE;
                end
            end
            ST_PEND_HI: begin
                if (raw_ovr || (raw && run_cnt == RUN_LAST)) begin
                    state_nxt = ST_HI;
                    run_nxt   = '0;
                    y_nxt     = 1'b1;
                end else if (!raw) begin
                    state_nxt = ST_LO;
                    run_nxt   = '0;
                end else begin
                    run_nxt = run_cnt + RUN_ONE;
                end
            end
            ST_HI: begin
                if (!raw && HOLD == 1) begin
                    state_nxt = ST_LO;
                    run_nxt   = '0;
                    y_nxt     = 1'b0;
                end else if (!raw) begin
                    state_nxt = ST_PEND_LO;
                    run_nxt   = RUN_ONE;
                end
            end
            ST_PEND_LO: begin
                if (raw) begin
                    state_nxt = ST_HI;
                    run_nxt   = '0;
                end else if (run_cnt == RUN_LAST) begin
                    state_nxt = ST_LO;
                    run_nxt   = '0;
                    y_nxt     = 1'b0;
                end else begin
                    run_nxt = run_cnt + RUN_ONE;
                end
            end
            default: begin
                state_nxt = ST_LO;
                run_nxt   = '0;
                y_nxt     = 1'b0;
            end
        endcase
    end

    assign going_up = en & y_nxt & ~y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw     <= 1'b0;
            raw_ovr <= 1'b0;
            state   <= ST_LO;
            run_cnt <= '0;
            y       <= 1'b0;
            rise    <= 1'b0;
            evt_cnt <= '0;
        end else begin
            if (en) begin
                raw     <= raw_d;
                raw_ovr <= ovr;
                state   <= state_nxt;
                run_cnt <= run_nxt;
                y       <= y_nxt;
            end
            rise <= going_up;
            // Clear wins over a coincident rise
            if (cnt_clr) begin
                evt_cnt <= '0;
            end else if (going_up && evt_cnt != CNT_MAX) begin
                evt_cnt <= evt_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vote_threshold_filter.sv
// tb/tb_vote_threshold_filter.sv - directed table and sequence checks for vote_threshold_filter
module tb_vote_threshold_filter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       ovr = 1'b0;
    logic [2:0] vote = 3'b000;
    logic [1:0] thr = 2'd2;
    logic       cnt_clr = 1'b0;
    logic       raw;
    logic       y;
    logic       rise;
    logic [1:0] evt_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       ovr;
        logic [2:0] vote;
        logic [1:0] thr;
        logic       exp_raw;
    } vec_t;

    vec_t vecs[19];

    vote_threshold_filter #(
        .N_VOTE (3),
        .HOLD   (4),
        .CNT_W  (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .ovr     (ovr),
        .vote    (vote),
        .thr     (thr),
        .cnt_clr (cnt_clr),
        .raw     (raw),
        .y       (y),
        .rise    (rise),
        .evt_cnt (evt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // vote=011 at thr=2 held: raw after 1 edge, y after 4 edges
    task automatic rise_by_vote(input int exp_cnt);
        vote = 3'b011;
        step();
        chk("s1_raw", raw, 1);
        chk("s1_y_early", y, 0);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("s1_y_wait", y, 0);
        end
        step();
        chk("s1_y", y, 1);
        chk("s1_rise", rise, 1);
        chk("s1_cnt", evt_cnt, exp_cnt);
        step();
        chk("s1_rise_drop", rise, 0);
    endtask

    // drive raw low and let y fall after HOLD edges
    task automatic fall_by_vote();
        vote = 3'b000;
        ovr  = 1'b0;
        step();
        chk("fall_raw", raw, 0);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("fall_y_wait", y, 1);
        end
        step();
        chk("fall_y", y, 0);
    endtask

    task automatic rise_by_ovr(input int exp_cnt);
        vote = 3'b000;
        ovr  = 1'b1;
        step();
        chk("ovr_raw", raw, 1);
        ovr = 1'b0;
        step();
        chk("ovr_y", y, 1);
        chk("ovr_rise", rise, 1);
        chk("ovr_cnt", evt_cnt, exp_cnt);
    endtask

    initial begin
        logic [15:0] tt_exp;
        int          exp_cnt;

        // ovr as A, vote as BCD, thr=2: A | at-least-2-of-BCD
        tt_exp = 16'b1111_1111_1110_1000;
        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{ovr: i[3], vote: i[2:0], thr: 2'd2, exp_raw: tt_exp[i]};
        end
        vecs[16] = '{ovr: 1'b0, vote: 3'b000, thr: 2'd0, exp_raw: 1'b1};
        vecs[17] = '{ovr: 1'b0, vote: 3'b111, thr: 2'd3, exp_raw: 1'b1};
        vecs[18] = '{ovr: 1'b0, vote: 3'b110, thr: 2'd3, exp_raw: 1'b0};

        #2;
        chk("rst_raw", raw, 0);
        chk("rst_y", y, 0);
        chk("rst_rise", rise, 0);
        chk("rst_cnt", evt_cnt, 0);
        #10;
        rst_n = 1'b1;
        step();

        rise_by_vote(1);

        // falling glitch: 3 cycles of raw=0 must not drop y
        vote = 3'b001;
        for (int i = 0; i < 3; i++) step();
        vote = 3'b011;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fall_glitch_y", y, 1);
        end
        fall_by_vote();

        // rising glitch: 3 cycles of raw=1 must not raise y
        vote = 3'b011;
        for (int i = 0; i < 3; i++) step();
        vote = 3'b001;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rise_glitch_y", y, 0);
        end
        chk("rise_glitch_cnt", evt_cnt, 1);

        // override: y next edge, falls four edges after raw drops
        rise_by_ovr(2);
        chk("ovr_raw_back", raw, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ovr_hold_y", y, 1);
        end
        step();
        chk("ovr_y_fall", y, 0);

        // saturation of the 2-bit counter
        exp_cnt = 2;
        for (int r = 0; r < 3; r++) begin
            exp_cnt = (exp_cnt < 3) ? exp_cnt + 1 : 3;
            rise_by_ovr(exp_cnt);
            for (int i = 0; i < 4; i++) step();
            chk("sat_y_low", y, 0);
        end
        chk("sat_cnt", evt_cnt, 3);

        // clear coincident with a rise
        ovr = 1'b1;
        step();
        ovr = 1'b0;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_y", y, 1);
        chk("clr_rise", rise, 1);
        chk("clr_cnt", evt_cnt, 0);
        for (int i = 0; i < 4; i++) step();
        chk("clr_y_low", y, 0);

        // en=0 during PEND_HI freezes raw, state and run_cnt
        vote = 3'b011;
        step();
        step();
        step();
        en = 1'b0;
        vote = 3'b000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("en_raw_hold", raw, 1);
            chk("en_y_hold", y, 0);
            chk("en_rise", rise, 0);
        end
        en = 1'b1;
        vote = 3'b011;
        step();
        chk("en_resume_y0", y, 0);
        step();
        chk("en_resume_y1", y, 1);
        chk("en_resume_cnt", evt_cnt, 1);

        // build evt_cnt=2 with y=1, then reset mid-filter
        fall_by_vote();
        rise_by_ovr(2);
        vote = 3'b000;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_raw", raw, 0);
        chk("arst_y", y, 0);
        chk("arst_rise", rise, 0);
        chk("arst_cnt", evt_cnt, 0);
        #3;
        rst_n = 1'b1;
        step();
        rise_by_vote(1);

        // cnt_clr honoured while en=0, y holds
        en = 1'b0;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_en0_cnt", evt_cnt, 0);
        chk("clr_en0_y", y, 1);
        en = 1'b1;

        for (int i = 0; i < 19; i++) begin
            ovr  = vecs[i].ovr;
            vote = vecs[i].vote;
            thr  = vecs[i].thr;
            step();
            chk($sformatf("tt_raw[%0d]", i), raw, vecs[i].exp_raw);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
